// File: rtl/micro_sequencer.sv
// Microprogram sequencer: steps upc through a 128-word ROM and registers the control word, with branches and self-loop halt.
// Optional datapath stall input is built in when SEQ_STALL_EN is defined.
module micro_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  flags,
`ifdef SEQ_STALL_EN
    input  logic        stall,
`endif
    input  logic [1:0]  condition,
    input  logic        BT,
    input  logic [58:0] OPs,
    input  logic [6:0]  jump_addr,
    output logic [15:0] upc,
    output logic [58:0] ops_q,
    output logic        ops_valid,
    output logic        running,
    output logic        halted,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [6:0]  r_upc;
    logic [58:0] r_ops_q;
    logic        r_ops_valid;
    logic        r_running;
    logic        r_halted;
    logic        r_ovf;

    logic        w_stall;
    logic        w_cond_true;
    logic        w_taken;
    logic        w_self_loop;
    logic        w_wrap;
    logic [6:0]  w_next;

`ifdef SEQ_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_cond_true = (condition == 2'b00) ? 1'b1     :
                         (condition == 2'b01) ? flags[0] :
                         (condition == 2'b10) ? flags[1] : flags[2];

    assign w_taken     = BT & w_cond_true;
    assign w_self_loop = w_taken && (condition == 2'b00) && (jump_addr == r_upc);
    // The 7-bit increment wraps 127 -> 0 naturally; ovf records that it happened.
    assign w_next      = w_taken ? jump_addr : r_upc + 7'd1;
    assign w_wrap      = !w_taken && (r_upc == 7'h7F);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_upc       <= '0;
            r_ops_q     <= '0;
            r_ops_valid <= 1'b0;
            r_running   <= 1'b0;
            r_halted    <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_upc       <= '0;
                    r_ops_q     <= '0;
                    r_ops_valid <= 1'b0;
                    if (start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_stall) begin
                        r_ops_valid <= 1'b0;
                    end else begin
                        r_ops_q     <= OPs;
                        r_ops_valid <= 1'b1;
                        r_upc       <= w_next;
                        if (w_wrap)
                            r_ovf <= 1'b1;
                        if (w_self_loop) begin
                            r_state   <= HALT;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    r_ops_q     <= '0;
                    r_ops_valid <= 1'b0;
                    if (start) begin
                        r_state   <= RUN;
                        r_upc     <= '0;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_upc       <= '0;
                    r_ops_q     <= '0;
                    r_ops_valid <= 1'b0;
                    r_running   <= 1'b0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    assign upc       = {9'b0, r_upc};
    assign ops_q     = r_ops_q;
    assign ops_valid = r_ops_valid;
    assign running   = r_running;
    assign halted    = r_halted;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed vector bench for micro_sequencer with a small behavioural microcode ROM.
// Build with SEQ_STALL_EN defined to also exercise the stall sequence.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  flags;
`ifdef SEQ_STALL_EN
    logic        stall;
`endif
    logic [1:0]  condition;
    logic        BT;
    logic [58:0] OPs;
    logic [6:0]  jump_addr;
    logic [15:0] upc;
    logic [58:0] ops_q;
    logic        ops_valid;
    logic        running;
    logic        halted;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;
    bit rom_linear = 1'b0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flags     (flags),
`ifdef SEQ_STALL_EN
        .stall     (stall),
`endif
        .condition (condition),
        .BT        (BT),
        .OPs       (OPs),
        .jump_addr (jump_addr),
        .upc       (upc),
        .ops_q     (ops_q),
        .ops_valid (ops_valid),
        .running   (running),
        .halted    (halted),
        .ovf       (ovf)
    );

    function automatic logic [58:0] word(input int a);
        logic [6:0] a7;
        a7 = 7'(a);
        return {a7, 45'h0, ~a7};
    endfunction

    // Microcode ROM: 5 -> 40 on flags[1], 6 -> 8 on flags[2], 8 -> 20 on flags[0], 9 self-loop halt.
    always_comb begin
        OPs       = word(int'(upc[6:0]));
        BT        = 1'b0;
        condition = 2'b00;
        jump_addr = 7'd0;
        if (!rom_linear) begin
            case (upc[6:0])
                7'd5: begin BT = 1'b1; condition = 2'b10; jump_addr = 7'd40; end
                7'd6: begin BT = 1'b1; condition = 2'b11; jump_addr = 7'd8;  end
                7'd8: begin BT = 1'b1; condition = 2'b01; jump_addr = 7'd20; end
                7'd9: begin BT = 1'b1; condition = 2'b00; jump_addr = 7'd9;  end
                default: ;
            endcase
        end
    end

    typedef struct {
        bit       rst;
        bit       start;
        bit [2:0] flags;
        int       upc;
        int       valid;
        int       ops;
        bit       run;
        bit       halt;
        bit       ovf;
    } vec_t;

    vec_t vt[$];

    // valid: -1 means don't care; ops: word address, -1 means zero, -2 don't care
    task automatic check(input string name, input int e_upc, input int e_valid, input int e_ops,
                         input bit e_run, input bit e_halt, input bit e_ovf);
        logic [58:0] e_word;
        bit bad;
        e_word = (e_ops == -1) ? 59'h0 : word(e_ops);
        bad = (int'(upc) != e_upc) || (running != e_run) || (halted != e_halt) || (ovf != e_ovf)
              || (e_valid >= 0 && ops_valid != 1'(e_valid)) || (e_ops != -2 && ops_q != e_word);
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got upc=%0d valid=%0b ops_q=%h run=%0b halt=%0b ovf=%0b, want upc=%0d valid=%0d ops_q=%h(dc=%0d) run=%0b halt=%0b ovf=%0b",
                     name, upc, ops_valid, ops_q, running, halted, ovf,
                     e_upc, e_valid, e_word, (e_ops == -2), e_run, e_halt, e_ovf);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        rst   = v.rst;
        start = v.start;
        flags = v.flags;
        @(posedge clk);
        #1;
        check(name, v.upc, v.valid, v.ops, v.run, v.halt, v.ovf);
    endtask

    task automatic add(input bit r, input bit s, input bit [2:0] f, input int u, input int va,
                       input int o, input bit ru, input bit h, input bit ov);
        vec_t v;
        v.rst = r; v.start = s; v.flags = f; v.upc = u; v.valid = va;
        v.ops = o; v.run = ru; v.halt = h; v.ovf = ov;
        vt.push_back(v);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flags = 3'b000;
`ifdef SEQ_STALL_EN
        stall = 1'b0;
`endif
        // Phase A: reset, idle, start, linear run, taken branch 5 -> 40
        add(1,0,3'b000,  0,0,-1, 0,0,0);
        add(1,0,3'b000,  0,0,-1, 0,0,0);
        add(0,0,3'b000,  0,0,-1, 0,0,0);
        add(0,0,3'b000,  0,0,-1, 0,0,0);
        add(0,0,3'b000,  0,0,-1, 0,0,0);
        add(0,1,3'b000,  0,0,-1, 1,0,0);
        add(0,0,3'b000,  1,1, 0, 1,0,0);
        add(0,0,3'b000,  2,1, 1, 1,0,0);
        add(0,0,3'b000,  3,1, 2, 1,0,0);
        add(0,0,3'b000,  4,1, 3, 1,0,0);
        add(0,0,3'b000,  5,1, 4, 1,0,0);
        add(0,0,3'b010, 40,1, 5, 1,0,0);
        add(0,0,3'b000, 41,1,40, 1,0,0);
        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("phaseA[%0d]", i));

        for (int a = 42; a <= 127; a++) begin
            @(posedge clk);
            #1;
            check($sformatf("seq_upc%0d", a), a, 1, a - 1, 1, 0, 0);
        end

        // Phase B: wrap, untaken/taken branches on other conditions, halt, restart, start ignored, rst mid-run
        vt.delete();
        add(0,0,3'b000,  0,1,127, 1,0,1);
        add(0,0,3'b000,  1,1, 0, 1,0,1);
        add(0,0,3'b000,  2,1, 1, 1,0,1);
        add(0,0,3'b000,  3,1, 2, 1,0,1);
        add(0,0,3'b000,  4,1, 3, 1,0,1);
        add(0,0,3'b000,  5,1, 4, 1,0,1);
        add(0,0,3'b000,  6,1, 5, 1,0,1);
        add(0,0,3'b100,  8,1, 6, 1,0,1);
        add(0,0,3'b110,  9,1, 8, 1,0,1);
        add(0,0,3'b000,  9,-1,9, 0,1,1);
        add(0,0,3'b000,  9,0,-1, 0,1,1);
        add(0,0,3'b111,  9,0,-1, 0,1,1);
        add(0,1,3'b000,  0,0,-1, 1,0,1);
        add(0,0,3'b000,  1,1, 0, 1,0,1);
        add(0,1,3'b000,  2,1, 1, 1,0,1);
        add(1,1,3'b000,  0,0,-1, 0,0,0);
        add(0,0,3'b000,  0,0,-1, 0,0,0);
        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("phaseB[%0d]", i));

`ifdef SEQ_STALL_EN
        // Stall at upc=12 for three cycles, with rst on the second
        rom_linear = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("stall_start", 0, 0, -1, 1, 0, 0);
        for (int a = 1; a <= 12; a++) begin
            @(posedge clk); #1;
            check($sformatf("stall_pre%0d", a), a, 1, a - 1, 1, 0, 0);
        end
        stall = 1'b1;
        @(posedge clk); #1;
        check("stall_c1", 12, 0, 11, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("stall_c2_rst", 0, 0, -1, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("stall_c3_idle", 0, 0, -1, 0, 0, 0);
        stall = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-002 Port start SHALL be in, 1 bit: one-cycle pulse that begins execution at microaddress 0.
REQ-003 Port flags SHALL be in, 3 bits: datapath status flags sampled for branch conditions.
REQ-004 Port stall SHALL be in, 1 bit: datapath not ready; present only when SEQ_STALL_EN is defined.
REQ-005 Ports condition (2 bits), BT (1 bit), OPs (59 bits) and jump_addr (7 bits) SHALL be inputs driven combinationally by the microcode ROM for the current upc.
REQ-006 Port upc SHALL be out, 16 bits: microprogram counter, wired to the ROM reg_out address input.
REQ-007 Port ops_q SHALL be out, 59 bits: registered control word to the datapath.
REQ-008 Port ops_valid SHALL be out, 1 bit: ops_q holds a control word to execute this cycle.
REQ-009 Ports running (1 bit), halted (1 bit) and ovf (1 bit, sticky) SHALL be outputs.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-011 In IDLE, upc SHALL be 0, ops_q 0 and ops_valid 0; start=1 SHALL move to RUN on the next edge with upc still 0.
REQ-012 In RUN, each non-stalled edge SHALL load ops_q<=OPs, set ops_valid<=1 and load upc<=next, giving a control-word latency of one cycle from upc=A to ops_q=word(A).
REQ-013 cond_true SHALL be 1 when condition=00, and otherwise flags[condition-1].
REQ-014 next SHALL be {9'b0,jump_addr} when BT=1 and cond_true=1; otherwise upc+1.
REQ-015 upc[15:7] SHALL always be 0; an increment from 127 SHALL wrap upc to 0 and set ovf, which stays set until rst.
REQ-016 In RUN, a taken branch with jump_addr equal to upc[6:0] and condition=00 (self-loop) SHALL go to HALT; on that edge ops_q is loaded as in REQ-012, and upc holds.
REQ-017 In HALT, upc SHALL hold, ops_q SHALL be 0 and ops_valid 0; start=1 SHALL return to RUN with upc=0.
REQ-018 In RUN, start SHALL be ignored.
REQ-019 running SHALL be 1 exactly in RUN, and halted SHALL be 1 exactly in HALT.
REQ-020 flags SHALL be sampled on the same edge that loads upc; there is no flag pipelining.

Reset
REQ-021 rst=1 SHALL have priority over start, stall and branches in every state, including mid-RUN.
REQ-022 On the edge with rst=1, the block SHALL enter IDLE with upc=0, ops_q=0, ops_valid=0, running=0, halted=0 and ovf=0.

Configuration
REQ-023 With SEQ_STALL_EN defined, stall=1 in RUN SHALL hold upc and ops_q and drive ops_valid=0 for that cycle, with no flag sampling, branch or ovf update.
REQ-024 Without SEQ_STALL_EN, the stall port SHALL be absent and treated internally as 0.

Verification
REQ-025 rst for 2 cycles, then idle for 3 cycles -> upc=0, ops_q=0, ops_valid=0, running=0 throughout.
REQ-026 start pulse, ROM with BT=0 at addresses 0..3 -> upc sequence 0,1,2,3,4 and ops_q=word(n) exactly one cycle after upc=n.
REQ-027 At upc=5, BT=1, condition=10, jump_addr=40 -> with flags=3'b010 upc=40 next; with flags=3'b000 upc=6 next.
REQ-028 Sequential run at upc=127 with BT=0 -> upc=0 and ovf=1, and ovf remains 1 after further cycles until rst.
REQ-029 At upc=9, BT=1, condition=00, jump_addr=9 -> HALT, halted=1, ops_valid=0, upc=9 held; a later start -> RUN with upc=0.
REQ-030 SEQ_STALL_EN defined, stall=1 for 3 cycles at upc=12 with rst asserted on cycle 2 -> upc holds 12 and ops_valid=0 until the rst edge, then IDLE state as in REQ-022.
